// File: rtl/atm_pkg.sv
// atm_pkg: shared encodings for the ATM ledger arbiter.
//   - op codes carried on req_op
//   - status codes returned on resp_status
//   - controller FSM state type
//   - reset balance of every ledger entry
package atm_pkg;

    localparam logic [1:0] OP_BAL = 2'b00;
    localparam logic [1:0] OP_WDR = 2'b01;
    localparam logic [1:0] OP_DEP = 2'b10;
    localparam logic [1:0] OP_XFR = 2'b11;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_INSUF = 2'b01;
    localparam logic [1:0] ST_OVF   = 2'b10;
    localparam logic [1:0] ST_BAD   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LATCH = 2'b01,
        S_EXEC  = 2'b10,
        S_RESP  = 2'b11
    } state_t;

    localparam logic [31:0] INIT_BAL = 32'h000186A0;

endpackage

// File: rtl/atm_ledger_arbiter_if.sv
// atm_ledger_arbiter_if: request/response bundle between the ATM sessions and the ledger.
//   req_valid/op/src/dst/amount : per-requester request fields, packed by requester index
//   req_ready                   : one-hot accept pulse
//   resp_valid                  : one-hot response pulse
//   resp_status/resp_balance    : shared response payload, valid with resp_valid
//   busy                        : controller not idle
// master = session side, slave = ledger controller side.
interface atm_ledger_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ACCT_W = 2,
    parameter int AMT_W  = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [2*N_REQ-1:0]      req_op;
    logic [ACCT_W*N_REQ-1:0] req_src;
    logic [ACCT_W*N_REQ-1:0] req_dst;
    logic [AMT_W*N_REQ-1:0]  req_amount;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        resp_valid;
    logic [1:0]              resp_status;
    logic [AMT_W-1:0]        resp_balance;
    logic                    busy;

    modport master (
        output req_valid, req_op, req_src, req_dst, req_amount,
        input  req_ready, resp_valid, resp_status, resp_balance, busy
    );

    modport slave (
        input  req_valid, req_op, req_src, req_dst, req_amount,
        output req_ready, resp_valid, resp_status, resp_balance, busy
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req       : request vector
//   ptr       : index searched first; search proceeds upward with wrap-around
//   gnt       : one-hot grant (all zero when nothing requested)
//   gnt_idx   : index of the granted requester
//   gnt_valid : any request present
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    int               j;
    logic [IDX_W-1:0] j_idx;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        j         = 0;
        j_idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j     = (int'(ptr) + i) % N_REQ;
            j_idx = IDX_W'(j);
            if (!gnt_valid && req[j_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = j_idx;
            end
        end
        if (gnt_valid) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// atm_ledger_arbiter: serialises balance/withdraw/deposit/transfer requests from N_REQ
// sessions onto a 2**ACCT_W-entry ledger, checking funds and overflow before any write.
//   clk, reset : clock, asynchronous active-high reset (ledger returns to INIT_BAL)
//   bus        : slave side of atm_ledger_arbiter_if (requests in, ready/response/busy out)
// One transaction at a time: IDLE (accept) -> LATCH (read) -> EXEC (check/write) -> RESP.
module atm_ledger_arbiter #(
    parameter int              N_REQ    = 4,
    parameter int              ACCT_W   = 2,
    parameter int              AMT_W    = 32,
    parameter logic [AMT_W-1:0] INIT_BAL = AMT_W'(atm_pkg::INIT_BAL)
) (
    input logic           clk,
    input logic           reset,
    atm_ledger_arbiter_if.slave bus
);
    import atm_pkg::*;

    localparam int IDX_W    = $clog2(N_REQ);
    localparam int NUM_ACCT = 2 ** ACCT_W;

    state_t state_q, state_d;

    logic [IDX_W-1:0]  ptr_q, gnt_idx_q, arb_idx;
    logic [N_REQ-1:0]  arb_gnt;
    logic              arb_valid;

    logic [1:0]        op_q;
    logic [ACCT_W-1:0] src_q, dst_q;
    logic [AMT_W-1:0]  amt_q, bal_src_q, bal_dst_q;
    logic [1:0]        status_q;
    logic [AMT_W-1:0]  balance_q;
    logic [AMT_W-1:0]  ledger_q [NUM_ACCT];

    logic [1:0]        op_arr  [N_REQ];
    logic [ACCT_W-1:0] src_arr [N_REQ];
    logic [ACCT_W-1:0] dst_arr [N_REQ];
    logic [AMT_W-1:0]  amt_arr [N_REQ];

    logic [1:0]        status_d;
    logic [AMT_W-1:0]  new_src, new_dst;
    logic              wr_src, wr_dst;
    logic [AMT_W:0]    dep_sum, xfr_sum;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign op_arr[i]  = bus.req_op[2*i +: 2];
        assign src_arr[i] = bus.req_src[ACCT_W*i +: ACCT_W];
        assign dst_arr[i] = bus.req_dst[ACCT_W*i +: ACCT_W];
        assign amt_arr[i] = bus.req_amount[AMT_W*i +: AMT_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (arb_valid) state_d = S_LATCH;
            S_LATCH: state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
        endcase
    end

    // Checks are ordered so BAD_ACCT beats INSUFFICIENT beats OVERFLOW.
    always_comb begin
        status_d = ST_OK;
        new_src  = bal_src_q;
        new_dst  = bal_dst_q;
        wr_src   = 1'b0;
        wr_dst   = 1'b0;
        dep_sum  = {1'b0, bal_src_q} + {1'b0, amt_q};
        xfr_sum  = {1'b0, bal_dst_q} + {1'b0, amt_q};
        unique case (op_q)
            OP_BAL: ;
            OP_WDR: begin
                if (amt_q > bal_src_q) begin
                    status_d = ST_INSUF;
                end else begin
                    new_src = bal_src_q - amt_q;
                    wr_src  = 1'b1;
                end
            end
            OP_DEP: begin
                if (dep_sum[AMT_W]) begin
                    status_d = ST_OVF;
                end else begin
                    new_src = dep_sum[AMT_W-1:0];
                    wr_src  = 1'b1;
                end
            end
            OP_XFR: begin
                if (src_q == dst_q) begin
                    status_d = ST_BAD;
                end else if (amt_q > bal_src_q) begin
                    status_d = ST_INSUF;
                end else if (xfr_sum[AMT_W]) begin
                    status_d = ST_OVF;
                end else begin
                    new_src = bal_src_q - amt_q;
                    new_dst = xfr_sum[AMT_W-1:0];
                    wr_src  = 1'b1;
                    wr_dst  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            op_q      <= OP_BAL;
            src_q     <= '0;
            dst_q     <= '0;
            amt_q     <= '0;
            bal_src_q <= '0;
            bal_dst_q <= '0;
            status_q  <= ST_OK;
            balance_q <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE: begin
                    if (arb_valid) begin
                        gnt_idx_q <= arb_idx;
                        op_q      <= op_arr[arb_idx];
                        src_q     <= src_arr[arb_idx];
                        dst_q     <= dst_arr[arb_idx];
                        amt_q     <= amt_arr[arb_idx];
                    end
                end
                S_LATCH: begin
                    bal_src_q <= ledger_q[src_q];
                    bal_dst_q <= ledger_q[dst_q];
                end
                S_EXEC: begin
                    status_q  <= status_d;
                    balance_q <= new_src;
                end
                S_RESP: begin
                    ptr_q <= (gnt_idx_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
                end
            endcase
        end
    end

    // Ledger changes only on the EXEC->RESP edge, so a reset earlier leaves no partial write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < NUM_ACCT; a++) begin
                ledger_q[a] <= INIT_BAL;
            end
        end else if (state_q == S_EXEC) begin
            if (wr_src) ledger_q[src_q] <= new_src;
            if (wr_dst) ledger_q[dst_q] <= new_dst;
        end
    end

    assign bus.req_ready    = (state_q == S_IDLE) ? arb_gnt : '0;
    assign bus.resp_valid   = (state_q == S_RESP) ? (N_REQ'(1) << gnt_idx_q) : '0;
    assign bus.resp_status  = status_q;
    assign bus.resp_balance = balance_q;
    assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// tb_atm_ledger_arbiter: directed bench for atm_ledger_arbiter with hand-computed expectations.
module tb_atm_ledger_arbiter;

    localparam int N_REQ  = 4;
    localparam int ACCT_W = 2;
    localparam int AMT_W  = 32;

    logic clk;
    logic reset;
    int   vectors;
    int   errors;

    atm_ledger_arbiter_if #(.N_REQ(N_REQ), .ACCT_W(ACCT_W), .AMT_W(AMT_W)) bus ();

    atm_ledger_arbiter #(
        .N_REQ  (N_REQ),
        .ACCT_W (ACCT_W),
        .AMT_W  (AMT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                         input logic [31:0] amt);
        bus.req_op     = {N_REQ{op}};
        bus.req_src    = {N_REQ{src}};
        bus.req_dst    = {N_REQ{dst}};
        bus.req_amount = {N_REQ{amt}};
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Accept at negedge of cycle T, response expected at negedge of cycle T+3.
    task automatic txn(input int r, input logic [1:0] op, input logic [1:0] src,
                       input logic [1:0] dst, input logic [31:0] amt,
                       input logic [1:0] est, input logic [31:0] ebal, input string tag);
        logic [3:0] oh;
        oh = 4'b0001 << r;
        @(negedge clk);
        drive(op, src, dst, amt);
        bus.req_valid = oh;
        #1;
        check({tag, ".ready"}, 32'(bus.req_ready), 32'(oh));
        @(negedge clk);
        bus.req_valid = '0;
        check({tag, ".busy"}, 32'(bus.busy), 32'd1);
        @(negedge clk);
        check({tag, ".early_resp"}, 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        check({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'(oh));
        check({tag, ".status"}, 32'(bus.resp_status), 32'(est));
        check({tag, ".balance"}, bus.resp_balance, ebal);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        reset   = 1'b1;
        bus.req_valid = '0;
        drive(2'b00, 2'd0, 2'd0, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        #1;
        check("rst.ready", 32'(bus.req_ready), 32'd0);
        check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst.status", 32'(bus.resp_status), 32'd0);
        check("rst.balance", bus.resp_balance, 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);

        // Balance, withdraw OK, withdraw insufficient
        txn(0, 2'b00, 2'd1, 2'd0, 32'd0,     2'b00, 32'd100000, "bal1");
        txn(1, 2'b01, 2'd0, 2'd0, 32'd30000, 2'b00, 32'd70000,  "wdr_ok");
        txn(1, 2'b01, 2'd0, 2'd0, 32'd80000, 2'b01, 32'd70000,  "wdr_insuf");
        txn(1, 2'b00, 2'd0, 2'd0, 32'd0,     2'b00, 32'd70000,  "bal0_after");

        // Transfer OK, destination credited, src==dst rejected with no write
        txn(2, 2'b11, 2'd2, 2'd3, 32'd40000, 2'b00, 32'd60000,  "xfr_ok");
        txn(2, 2'b00, 2'd3, 2'd0, 32'd0,     2'b00, 32'd140000, "bal3");
        txn(2, 2'b11, 2'd1, 2'd1, 32'd10,    2'b11, 32'd100000, "xfr_bad");
        txn(3, 2'b11, 2'd1, 2'd1, 32'd500000, 2'b11, 32'd100000, "xfr_bad_prio");
        txn(3, 2'b00, 2'd1, 2'd0, 32'd0,     2'b00, 32'd100000, "bal1_after");

        // Overflow and zero-amount deposit on a fresh ledger
        do_reset();
        txn(0, 2'b10, 2'd0, 2'd0, 32'hFFFF0000, 2'b10, 32'd100000, "dep_ovf");
        txn(0, 2'b10, 2'd0, 2'd0, 32'd0,        2'b00, 32'd100000, "dep_zero");
        txn(0, 2'b10, 2'd1, 2'd0, 32'd5,        2'b00, 32'd100005, "dep_ok");
        txn(1, 2'b11, 2'd2, 2'd3, 32'd200000,   2'b01, 32'd100000, "xfr_insuf");
        txn(1, 2'b11, 2'd2, 2'd1, 32'hFFFFFFFF, 2'b01, 32'd100000, "xfr_insuf_prio");

        // All four requesters continuously valid: grants 0,1,2,3,0 spaced 4 cycles
        do_reset();
        @(negedge clk);
        drive(2'b00, 2'd2, 2'd0, 32'd0);
        bus.req_valid = 4'hF;
        #1;
        check("rr.grant0", 32'(bus.req_ready), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("rr.quiet%0d", k), 32'(bus.req_ready), 32'd0);
            @(negedge clk);
            @(negedge clk);
            check($sformatf("rr.resp%0d", k - 1), 32'(bus.resp_valid),
                  32'(4'b0001 << ((k - 1) % 4)));
            @(negedge clk);
            #1;
            check($sformatf("rr.grant%0d", k), 32'(bus.req_ready), 32'(4'b0001 << (k % 4)));
        end
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("rr.resp_last", 32'(bus.resp_valid), 32'h1);
        check("rr.status_last", 32'(bus.resp_status), 32'd0);

        // Reset during EXEC of a withdraw aborts with no write
        @(negedge clk);
        drive(2'b01, 2'd0, 2'd0, 32'd50000);
        bus.req_valid = 4'h1;
        #1;
        check("abort.ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort.busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("abort.resp_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        check("abort.resp_valid2", 32'(bus.resp_valid), 32'd0);
        reset = 1'b0;
        txn(0, 2'b00, 2'd0, 2'd0, 32'd0, 2'b00, 32'd100000, "abort.bal0");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/atm_ledger_arbiter.md
Name: atm_ledger_arbiter

Overview:
Shared account-ledger controller for the ATM banking system. Arbitrates balance, withdraw, deposit and transfer requests from N_REQ ATM session FSMs onto one internal ledger of account balances. Serialises the requests and runs a funds and overflow check before any write. Transfers commit both accounts atomically. Each requester gets a one-cycle response carrying a status code and the resulting balance.

Parameters:
N_REQ, 4, number of requesting ATM sessions (≥2)
ACCT_W, 2, account index width; ledger holds 2**ACCT_W accounts
AMT_W, 32, balance/amount width (unsigned)
INIT_BAL, 32'h000186A0, reset value of every ledger entry (100000)

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
req_valid  in  N_REQ  per-requester request; held until matching req_ready
req_op  in  2*N_REQ  per-requester op: 00 balance, 01 withdraw, 10 deposit, 11 transfer
req_src  in  ACCT_W*N_REQ  source/own account index
req_dst  in  ACCT_W*N_REQ  destination account (transfer only)
req_amount  in  AMT_W*N_REQ  amount (ignored for balance)
req_ready  out  N_REQ  one-hot, 1-cycle accept pulse
resp_valid  out  N_REQ  one-hot, 1-cycle response pulse
resp_status  out  2  00 OK, 01 INSUFFICIENT, 10 OVERFLOW, 11 BAD_ACCT
resp_balance  out  AMT_W  src balance after the op (unchanged on failure)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_status=00, resp_balance=0, busy=0, FSM=IDLE, rr_ptr=0, all ledger entries=INIT_BAL.
- FSM states: IDLE → LATCH → EXEC → RESP → IDLE. One transaction at a time; no pipelining.
- IDLE:
  - If any req_valid is high, grant the first valid index found searching from rr_ptr upward with wrap-around.
  - Pulse req_ready[g] in the same cycle (combinational on the IDLE state, registered grant index).
  - Latch op, src, dst and amount; go to LATCH.
- LATCH: read ledger[src] and ledger[dst] into registers.
- EXEC: compute status and new balances.
  - balance: status OK, no write.
  - withdraw: if amount > bal_src, status INSUFFICIENT; else bal_src−amount.
  - deposit: use an AMT_W+1-bit sum. Carry set gives OVERFLOW; else bal_src+amount.
  - transfer: src==dst gives BAD_ACCT. Else amount > bal_src gives INSUFFICIENT. Else bal_dst+amount carry gives OVERFLOW. Else debit src and credit dst in the same clock edge.
  - Check priority: BAD_ACCT > INSUFFICIENT > OVERFLOW.
  - Ledger is written only on OK, only at the EXEC→RESP edge.
  - amount=0 is legal and returns OK.
- RESP:
  - resp_valid[g]=1 for one cycle; resp_status and resp_balance are valid in that cycle and hold until the next RESP.
  - rr_ptr ← g+1 mod N_REQ.
- Latency: accept in cycle T, response in T+3. Next grant no earlier than T+4.
- Fairness: a continuously valid requester is served within N_REQ transactions.
- Simultaneous requests: only one grant per IDLE cycle. Non-granted requests stay pending; their req_valid must remain high.
- req_valid dropped before req_ready: request is withdrawn with no side effect.
- Reset mid-transaction: aborts with no partial write, since the ledger is only written at the EXEC edge. Ledger reinitialises to INIT_BAL.
- Out-of-range indices are not possible; ACCT_W fully decodes the ledger.

Decomposition:
- Package atm_pkg holds:
  - op encodings OP_BAL, OP_WDR, OP_DEP, OP_XFR
  - status encodings ST_OK, ST_INSUF, ST_OVF, ST_BAD
  - FSM state localparams
  - INIT_BAL constant
- Sub-module rr_arbiter (N_REQ, req vector + ptr in, one-hot grant + index out), purely combinational.
- Ledger register file and check logic stay in the top module.

Test Plan:
1. Reset, then requester 0 sends balance on acct 1 → req_ready[0] at T, resp_valid[0] at T+3, status 00, balance 100000.
2. Requester 1 withdraws 30000 from acct 0, then 80000 from acct 0 → first OK with 70000; second INSUFFICIENT with 70000, ledger unchanged.
3. Requester 2 transfers 40000 from acct 2 to acct 3, then balance on acct 3 → OK with 60000; then 140000. Transfer src=dst=1 → BAD_ACCT, no write.
4. Deposit 32'hFFFF0000 into acct 0 (100000) → OVERFLOW, balance stays 100000. Deposit 0 → OK.
5. All four requesters hold valid continuously → grants in order 0,1,2,3,0, each spaced 4 cycles; no starvation.
6. Assert reset during EXEC of a 50000 withdraw on acct 0 → no resp_valid; after release, balance on acct 0 returns 100000.
